// File: rtl/fp16_pkg.sv
// Shared FP16 constants, FSM encoding and special-operand classification
// for the sequential half-precision divider.
package fp16_pkg;

    localparam int          FP16_BIAS    = 15;
    localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;
    localparam logic [15:0] FP16_QNAN    = 16'h7C01;
    localparam int          EXP_W        = 5;
    localparam int          MANT_W       = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRENORM = 3'd1,
        ST_DIVIDE  = 3'd2,
        ST_POST    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    typedef struct packed {
        logic        hit;
        logic [15:0] res;
    } special_t;

    // Ordered classification: the first matching rule decides the result.
    function automatic special_t fp16_special(input logic [15:0] op_a, input logic [15:0] op_b);
        special_t   sp;
        logic       sgn;
        logic       a_max, b_max, a_fz, b_fz;
        logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        sgn    = op_a[15] ^ op_b[15];
        a_max  = (op_a[MANT_W +: EXP_W] == FP16_EXP_MAX);
        b_max  = (op_b[MANT_W +: EXP_W] == FP16_EXP_MAX);
        a_fz   = (op_a[MANT_W-1:0] == '0);
        b_fz   = (op_b[MANT_W-1:0] == '0);
        a_nan  = a_max && !a_fz;
        b_nan  = b_max && !b_fz;
        a_inf  = a_max && a_fz;
        b_inf  = b_max && b_fz;
        a_zero = (op_a[MANT_W +: EXP_W] == '0) && a_fz;
        b_zero = (op_b[MANT_W +: EXP_W] == '0) && b_fz;
        sp.hit = 1'b1;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            sp.res = FP16_QNAN;
        end else if (a_inf || b_zero) begin
            sp.res = {sgn, FP16_EXP_MAX, {MANT_W{1'b0}}};
        end else if (a_zero || b_inf) begin
            sp.res = {sgn, 15'b0};
        end else begin
            sp.hit = 1'b0;
            sp.res = 16'h0000;
        end
        return sp;
    endfunction

endpackage

// File: rtl/fp16_lzc11.sv
// Combinational leading-zero count of an 11-bit mantissa (11 for all-zero).
module fp16_lzc11 (
    input  logic [10:0] val_i,
    output logic [3:0]  cnt_o
);

    // Ascending scan: the highest set bit is the last to write the count.
    always_comb begin
        cnt_o = 4'd11;
        for (int i = 0; i < 11; i++) begin
            if (val_i[i]) begin
                cnt_o = 4'(10 - i);
            end
        end
    end

endmodule

// File: rtl/fp16_div_seq.sv
// Sequential IEEE-754 half-precision divider: one restoring quotient bit per
// clock, truncating, with one operation in flight and a valid/ready handshake.
module fp16_div_seq
    import fp16_pkg::*;
#(
    parameter int ITER = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result
);

    state_t             state_q, state_d;
    logic [15:0]        a_q, a_d;
    logic [15:0]        b_q, b_d;
    logic               sign_q, sign_d;
    logic [10:0]        mb_q, mb_d;
    logic [11:0]        rem_q, rem_d;
    logic [11:0]        quo_q, quo_d;
    logic signed [6:0]  exp_q, exp_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [15:0]        result_q, result_d;

    special_t           sp;
    logic [4:0]         ea_raw, eb_raw;
    logic [10:0]        mant_a_raw, mant_b_raw;
    logic [10:0]        mant_a_norm, mant_b_norm;
    logic [3:0]         lz_a, lz_b;
    logic signed [6:0]  ea_eff, eb_eff, exp_pre;

    logic               rem_ge;
    logic [11:0]        rem_sub;

    logic signed [6:0]  exp_adj;
    logic [9:0]         frac;
    logic [6:0]         den_sh;
    logic [9:0]         den_mant;
    logic [15:0]        post_res;

    assign sp = fp16_special(a, b);

    // Hidden bit is 1 for normals, so the count is zero for them and only
    // denormals get shifted up to 1.f.
    assign ea_raw     = a_q[MANT_W +: EXP_W];
    assign eb_raw     = b_q[MANT_W +: EXP_W];
    assign mant_a_raw = {(ea_raw != '0), a_q[MANT_W-1:0]};
    assign mant_b_raw = {(eb_raw != '0), b_q[MANT_W-1:0]};

    fp16_lzc11 u_lzc_a (
        .val_i (mant_a_raw),
        .cnt_o (lz_a)
    );

    fp16_lzc11 u_lzc_b (
        .val_i (mant_b_raw),
        .cnt_o (lz_b)
    );

    assign mant_a_norm = mant_a_raw << lz_a;
    assign mant_b_norm = mant_b_raw << lz_b;
    assign ea_eff      = (ea_raw == '0) ? 7'(7'd1 - 7'(lz_a)) : 7'(ea_raw);
    assign eb_eff      = (eb_raw == '0) ? 7'(7'd1 - 7'(lz_b)) : 7'(eb_raw);
    assign exp_pre     = ea_eff - eb_eff + 7'(FP16_BIAS);

    // Remainder stays below twice the divisor, so 12 bits never overflow.
    assign rem_ge  = (rem_q >= {1'b0, mb_q});
    assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

    assign exp_adj  = quo_q[11] ? exp_q : (exp_q - 7'sd1);
    assign frac     = quo_q[11] ? quo_q[10:1] : quo_q[9:0];
    assign den_sh   = 7'(7'd1 - 7'(exp_adj));
    assign den_mant = 10'({1'b1, frac} >> den_sh);

    always_comb begin
        post_res = {sign_q, exp_adj[4:0], frac};
        if (exp_adj >= 7'sd31) begin
            post_res = {sign_q, FP16_EXP_MAX, {MANT_W{1'b0}}};
        end else if (exp_adj <= 7'sd0) begin
            post_res = {sign_q, 5'b0, den_mant};
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        mb_d      = mb_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        exp_d     = exp_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d = a;
                    b_d = b;
                    if (sp.hit) begin
                        result_d = sp.res;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_PRENORM;
                    end
                end
            end
            ST_PRENORM: begin
                sign_d  = a_q[15] ^ b_q[15];
                mb_d    = mant_b_norm;
                rem_d   = {1'b0, mant_a_norm};
                quo_d   = '0;
                exp_d   = exp_pre;
                cnt_d   = '0;
                state_d = ST_DIVIDE;
            end
            ST_DIVIDE: begin
                rem_d = rem_sub << 1;
                quo_d = {quo_q[10:0], rem_ge};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(ITER - 1)) begin
                    state_d = ST_POST;
                end
            end
            ST_POST: begin
                result_d = post_res;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            mb_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            mb_q     <= mb_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_fp16_div_seq.sv
// Scoreboard bench for fp16_div_seq: the driver queues expected results, a
// negedge monitor pops and checks value, latency and hold-while-stalled.
module tb_fp16_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] result;

    always #5 clk = ~clk;

    fp16_div_seq #(.ITER(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_res;
        int          lat;
        longint      t_acc;
        string       nm;
    } txn_t;

    txn_t   sb[$];
    txn_t   cur;
    int     total = 0;
    int     bad = 0;
    bit     seen = 1'b0;
    logic [15:0] held;
    longint t_first;
    int     lat_meas;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Clock period 10, accept at posedge T, first valid seen at negedge:
    // latency in clocks = (t_neg - T - 5)/10 + 1.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                seen    = 1'b1;
                t_first = longint'($time);
                held    = result;
                check("in_ready_low_in_done", 32'(in_ready), 32'd0);
            end else begin
                check("result_stable", 32'(result), 32'(held));
            end
            if (out_ready) begin
                seen = 1'b0;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out_valid: got result %h with no pending op", result);
                end else begin
                    cur      = sb.pop_front();
                    lat_meas = int'((t_first - cur.t_acc - 5) / 10) + 1;
                    check({cur.nm, "_result"}, 32'(result), 32'(cur.exp_res));
                    check({cur.nm, "_latency"}, 32'(lat_meas), 32'(cur.lat));
                    $display("txn %s: a=%h b=%h result=%h (want %h) latency=%0d (want %0d)",
                             cur.nm, cur.a, cur.b, result, cur.exp_res, lat_meas, cur.lat);
                end
            end
        end
    end

    // Caller is at posedge+1. Normal ops keep in_valid high with junk for a
    // few cycles after accept to show the busy block ignores it.
    task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic [15:0] er,
                         input int lat, input string nm, input bit track);
        txn_t t;
        int   n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL %s_accept_timeout: in_ready got 0 want 1", nm);
            return;
        end
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        t.a = va; t.b = vb; t.exp_res = er; t.lat = lat; t.nm = nm;
        t.t_acc = longint'($time);
        if (track) sb.push_back(t);
        #1;
        if (track && lat > 1) begin
            for (int k = 0; k < 3; k++) begin
                a = 16'($urandom);
                b = 16'($urandom);
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({nm, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        int n_valid;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(result), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(16'h3C00, 16'h4000, 16'h3800, 15, "one_div_two", 1'b1);
        issue(16'h3C00, 16'h4200, 16'h3555, 15, "one_div_three", 1'b1);
        issue(16'h3C00, 16'h0000, 16'h7C00, 1,  "nonzero_div_zero", 1'b1);
        issue(16'h0000, 16'h0000, 16'h7C01, 1,  "zero_div_zero", 1'b1);
        issue(16'h7C00, 16'hFC00, 16'h7C01, 1,  "inf_div_inf", 1'b1);
        issue(16'h8000, 16'h4000, 16'h8000, 1,  "negzero_div_two", 1'b1);
        issue(16'h0001, 16'h3C00, 16'h0001, 15, "denorm_div_one", 1'b1);
        issue(16'h7BFF, 16'h0001, 16'h7C00, 15, "overflow", 1'b1);
        issue(16'h0001, 16'h7BFF, 16'h0000, 15, "underflow", 1'b1);
        drain("directed");

        // Back-pressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        issue(16'h4400, 16'h3C00, 16'h4400, 15, "stall_four_div_one", 1'b1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_valid_seen", 32'(out_valid), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("stall_valid_held", 32'(out_valid), 32'd1);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_queue_pending", 32'(sb.size()), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_idle_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        issue(16'hC000, 16'h4000, 16'hBC00, 15, "b2b_neg_two_div_two", 1'b1);
        drain("stall");

        // Reset during DIVIDE cycle 6 aborts without a result.
        issue(16'h3C00, 16'h4200, 16'h3555, 15, "aborted", 1'b0);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", 32'(result), 32'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_valid = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (out_valid) n_valid++;
        end
        check("abort_no_out_valid", 32'(n_valid), 32'd0);
        @(posedge clk);
        #1;
        issue(16'h4400, 16'h4000, 16'h4000, 15, "post_reset_four_div_two", 1'b1);
        drain("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp16_div_seq.md
FP16_DIV_SEQ -- requirements
Module: fp16_div_seq

Interface
REQ-001 SHALL: parameter ITER, default 12, number of quotient-bit iterations (fixed 12, not user-tunable in this revision).
REQ-002 SHALL: clk  input  1  single clock, rising edge.
REQ-003 SHALL: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL: in_valid  input  1  operands a, b valid.
REQ-005 SHALL: in_ready  output  1  block accepts operands.
REQ-006 SHALL: a  input  16  IEEE-754 half dividend.
REQ-007 SHALL: b  input  16  IEEE-754 half divisor.
REQ-008 SHALL: out_valid  output  1  result valid.
REQ-009 SHALL: out_ready  input  1  consumer accepts result.
REQ-010 SHALL: result  output  16  half quotient a/b.

Function
REQ-011 SHALL: FSM states IDLE, PRENORM, DIVIDE, POST, DONE, with one operation in flight at a time.
REQ-012 SHALL: in_ready=1 only in IDLE; transfer when in_valid&&in_ready; a, b captured on that edge.
REQ-013 SHALL: on accept, special operand → DONE on next edge; else → PRENORM.
REQ-014 SHALL: special results are first match wins, in this order:
  - either NaN, 0/0, inf/inf → 16'h7C01;
  - inf/finite, or nonzero/0 → {sa^sb, 5'h1F, 0};
  - 0/nonzero, or finite/inf → {sa^sb, 15'b0}.
REQ-015 SHALL: PRENORM (1 cycle) normalizes denormal mantissas to 1.f using a leading-zero count; effective exponent = 1 − shift.
REQ-015 also SHALL: set exp = ea_eff − eb_eff + 15, signed 7-bit.
REQ-016 SHALL: DIVIDE runs exactly 12 restoring radix-2 iterations, one quotient bit per cycle, MSB first; q[11] weight 2^0, q[0] weight 2^-11.
REQ-017 SHALL: POST (1 cycle) normalizes, then packs:
  - normalize: if q[11], frac=q[10:1]; else frac=q[9:0], exp−1;
  - exp≥31 → signed inf;
  - exp≤0 → denormal {1,frac}>>(1−exp), zero if shifted out;
  - truncate, no rounding.
REQ-018 SHALL: DONE holds out_valid=1 and result stable until out_ready=1, then → IDLE on that edge.
REQ-019 SHALL: normal latency is 15 clocks from accepting edge to out_valid; special latency is 1 clock.
REQ-020 SHALL: result sign = sa^sb for all non-NaN results, including zero and inf.
REQ-021 SHALL: in_valid is ignored outside IDLE, and a/b changes after accept do not affect the result.

Reset
REQ-022 SHALL: rst_n low asynchronously forces IDLE, in_ready=1, out_valid=0, result=16'h0000, and clears iteration counter and datapath registers.
REQ-023 SHALL: reset mid-operation aborts the operation without producing out_valid; the first accept after release behaves as from power-up.

Structure
REQ-024 SHALL: shared package fp16_pkg holds these constants:
  - FP16_BIAS=15, FP16_EXP_MAX=5'h1F, FP16_QNAN=16'h7C01;
  - field widths (EXP_W=5, MANT_W=10);
  - FSM state encoding.
REQ-025 SHALL: one sub-module fp16_lzc11 (combinational 11-bit leading-zero count) is instantiated twice in PRENORM.

Verification
REQ-026 SHALL: a=3C00, b=4000 → result 3800, out_valid 15 clocks after accept.
REQ-027 SHALL: a=3C00, b=4200 → 3555 (truncated 1/3).
REQ-028 SHALL: these special cases give out_valid 1 clock after accept:
  - 3C00/0000 → 7C00;
  - 0000/0000 → 7C01;
  - 7C00/FC00 → 7C01;
  - 8000/4000 → 8000.
REQ-029 SHALL: boundary cases:
  - 0001/3C00 → 0001 (denormal in/out);
  - 7BFF/0001 → 7C00 (overflow);
  - 0001/7BFF → 0000 (underflow).
REQ-030 SHALL: with out_ready held low for 20 cycles, out_valid and result stay stable and in_ready=0. On out_ready=1, the next edge moves to IDLE, and a back-to-back second operation completes correctly.
REQ-031 SHALL: asserting rst_n low in DIVIDE cycle 6 → out_valid never rises for that operation, and in_ready=1 immediately. A post-release 4400/4000 → 4000.
